controle_ajuste: RTL and testbench

- Time-base and time-set controller for the HH:MM:SS clock datapath.
- In RUN it issues the 1 Hz seconds enable to the seconds counter.
- In the set modes it converts debounced button presses into single increment pulses for the hour or minute counter, and blinks the digit pair being edited.
- Sits between the raw board buttons and the seconds/minutes/hours counter machines. Its outputs are the only enables those counters receive.

---
 rtl/controle_ajuste.sv | 191 +++++++++++++++++++
 tb/tb_controle_ajuste.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/controle_ajuste.sv
// controle_ajuste: time-base and time-set controller for the HH:MM:SS clock datapath.
// Ports: clock, reset (async active-low); btn_mode/btn_inc raw buttons; sec_en/sec_clear
//   to the seconds counter; min_inc/hour_inc increments; blank_h/blank_m; mode (00 RUN, 01 SET_H, 10 SET_M).
// All outputs are registered. A raw button edge reaches the controller 3 + DEBOUNCE_CYCLES cycles later.

// Synchronizer plus debouncer for one raw button.
// The level follows the synced input only after it has disagreed for CYCLES consecutive cycles.
module controle_ajuste_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any cycle that agrees with the current level restarts the count.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module controle_ajuste #(
  parameter int CLK_HZ          = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       sec_en,
  output logic       sec_clear,
  output logic       min_inc,
  output logic       hour_inc,
  output logic       blank_h,
  output logic       blank_m,
  output logic [1:0] mode
);
  typedef enum logic [1:0] {
    RUN   = 2'b00,
    SET_H = 2'b01,
    SET_M = 2'b10
  } state_t;

  localparam int DW = $clog2(CLK_HZ);
  localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_HZ / 2);
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW = $clog2(HMAX + 1);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] REP_C  = CW'(REPEAT_CYCLES);

  state_t        state;
  state_t        state_nx;
  logic [DW-1:0] div;
  logic          mode_lvl;
  logic          inc_lvl;
  logic          mode_lvl_q;
  logic          inc_lvl_q;
  logic          mode_press;
  logic          inc_press;
  logic [CW-1:0] hold_cnt;
  logic          repeating;
  logic          hold_run;
  logic          rep_pulse;
  logic          inc_evt;

  controle_ajuste_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clock (clock),
    .reset (reset),
    .raw   (btn_mode),
    .level (mode_lvl)
  );

  controle_ajuste_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clock (clock),
    .reset (reset),
    .raw   (btn_inc),
    .level (inc_lvl)
  );

  // Press pulses fire the cycle after the debounced level rises.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_lvl_q <= 1'b0;
      inc_lvl_q  <= 1'b0;
      mode_press <= 1'b0;
      inc_press  <= 1'b0;
    end else begin
      mode_lvl_q <= mode_lvl;
      inc_lvl_q  <= inc_lvl;
      mode_press <= mode_lvl & ~mode_lvl_q;
      inc_press  <= inc_lvl & ~inc_lvl_q;
    end
  end

  always_comb begin
    state_nx = state;
    if (mode_press) begin
      case (state)
        RUN:     state_nx = SET_H;
        SET_H:   state_nx = SET_M;
        default: state_nx = RUN;
      endcase
    end
  end

  // Auto-repeat: the counter restarts at each press and each repeat pulse, so the
  // first pulse lands HOLD_CYCLES after the press and later ones every REPEAT_CYCLES.
  // A release, RUN, or a mode press clears it.
  assign hold_run  = inc_lvl && (state != RUN) && !mode_press;
  assign rep_pulse = hold_run && (hold_cnt == (repeating ? REP_C : HOLD_C));
  // A press coinciding with a repeat still yields a single increment; mode wins over inc.
  assign inc_evt   = (inc_press || rep_pulse) && !mode_press;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_cnt  <= '0;
      repeating <= 1'b0;
    end else if (!hold_run) begin
      hold_cnt  <= '0;
      repeating <= 1'b0;
    end else if (inc_press) begin
      hold_cnt  <= CW'(1);
      repeating <= 1'b0;
    end else if (rep_pulse) begin
      hold_cnt  <= CW'(1);
      repeating <= 1'b1;
    end else begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // Mode FSM, divider and all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      div       <= '0;
      sec_en    <= 1'b0;
      sec_clear <= 1'b0;
      min_inc   <= 1'b0;
      hour_inc  <= 1'b0;
      blank_h   <= 1'b0;
      blank_m   <= 1'b0;
    end else begin
      state <= state_nx;
      // Restart the second on leaving SET_M so the first tick is a full second away.
      if (state == SET_M && mode_press) begin
        div <= '0;
      end else if (div == DIV_MAX) begin
        div <= '0;
      end else begin
        div <= div + 1'b1;
      end
      // Registered off the divider's last count, so the pulse lands on the wrap cycle.
      sec_en    <= (state == RUN) && !mode_press && (div == DIV_MAX);
      sec_clear <= (state == SET_M) && mode_press;
      hour_inc  <= (state == SET_H) && inc_evt;
      min_inc   <= (state == SET_M) && inc_evt;
      // Blank the edited pair for the second half of each divider period.
      blank_h   <= (state_nx == SET_H) && (div >= DIV_HALF);
      blank_m   <= (state_nx == SET_M) && (div >= DIV_HALF);
    end
  end

  assign mode = state;
endmodule

// File: tb/tb_controle_ajuste.sv
// Bench for controle_ajuste with CLK_HZ=10, DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5.
// Cycle k is the interval after the k-th rising edge following a reference point.
// Outputs are sampled 1 time unit after each rising edge.
module tb_controle_ajuste;
  localparam int CLK_HZ = 10;
  localparam int DEB    = 4;
  localparam int HOLD   = 20;
  localparam int REP    = 5;

  // Output vector layout: {sec_en, sec_clear, min_inc, hour_inc, blank_h, blank_m, mode[1:0]}
  localparam logic [7:0] O_IDLE  = 8'b0000_0000;
  localparam logic [7:0] O_SEC   = 8'b1000_0000;
  localparam logic [7:0] O_SETH  = 8'b0000_0001;
  localparam logic [7:0] O_SETHB = 8'b0000_1001;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       sec_en, sec_clear, min_inc, hour_inc, blank_h, blank_m;
  logic [1:0] mode;

  int nvec = 0;
  int nmis = 0;
  int cyc = 0;
  int excl_viol = 0;

  typedef struct {
    logic       bm;
    logic       bi;
    int         n;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[$];

  int hcnt, mcnt, scnt, r0, clr_at, sec_at, nclr, early;
  logic [1:0] clr_mode;
  int offs[$];
  int exp_off[5] = '{8, 28, 33, 38, 43};

  always #5 clock = ~clock;

  controle_ajuste #(
    .CLK_HZ          (CLK_HZ),
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .sec_en    (sec_en),
    .sec_clear (sec_clear),
    .min_inc   (min_inc),
    .hour_inc  (hour_inc),
    .blank_h   (blank_h),
    .blank_m   (blank_m),
    .mode      (mode)
  );

  always @(negedge clock) begin
    if (reset && ((int'(sec_en) + int'(min_inc) + int'(hour_inc)) > 1)) excl_viol++;
  end

  function automatic logic [7:0] outs();
    return {sec_en, sec_clear, min_inc, hour_inc, blank_h, blank_m, mode};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic chk8(input string nm, input logic [7:0] got, input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %b want %b", nm, got, exp);
    end
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nmis++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  task automatic add(input logic bm, input logic bi, input int n, input logic [7:0] e);
    vec_t v;
    v.bm = bm; v.bi = bi; v.n = n; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    repeat (10) tick();
    btn_mode = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    // Idle after reset: sec_en on cycles 10, 20, 30.
    add(0, 0, 9, O_IDLE); add(0, 0, 1, O_SEC);
    add(0, 0, 9, O_IDLE); add(0, 0, 1, O_SEC);
    add(0, 0, 9, O_IDLE); add(0, 0, 1, O_SEC);
    add(0, 0, 5, O_IDLE);
    // Three-cycle bounce on btn_mode: must be rejected.
    add(1, 0, 3, O_IDLE); add(0, 0, 1, O_IDLE); add(0, 0, 1, O_SEC);
    add(0, 0, 4, O_IDLE);
    // Held btn_mode from cycle 45: SET_H appears at cycle 52 (raw edge after 44, +8).
    add(1, 0, 5, O_IDLE); add(1, 0, 1, O_SEC); add(1, 0, 1, O_IDLE);
    add(1, 0, 4, O_SETH); add(1, 0, 5, O_SETHB);
    add(1, 0, 5, O_SETH); add(1, 0, 5, O_SETHB);
    add(0, 0, 5, O_SETH);

    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk8("reset_state", outs(), O_IDLE);
    reset = 1'b1;
    cyc = 0;

    foreach (tbl[v]) begin
      for (int i = 0; i < tbl[v].n; i++) begin
        btn_mode = tbl[v].bm;
        btn_inc  = tbl[v].bi;
        tick();
        chk8($sformatf("vec%0d_cyc%0d", v, cyc), outs(), tbl[v].exp);
      end
    end

    // SET_H: three taps of btn_inc give three hour increments.
    hcnt = 0; mcnt = 0; scnt = 0;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 20; i++) begin
        btn_inc = (i < 10);
        tick();
        hcnt += int'(hour_inc); mcnt += int'(min_inc); scnt += int'(sec_en);
      end
    end
    repeat (10) begin
      tick();
      hcnt += int'(hour_inc); mcnt += int'(min_inc); scnt += int'(sec_en);
    end
    chki("tap_hour_inc", hcnt, 3);
    chki("tap_min_inc", mcnt, 0);
    chki("tap_sec_en", scnt, 0);

    // SET_M: hold btn_inc for 40 cycles; press then repeats at +20, +25, +30, +35.
    press_mode();
    chki("mode_set_m", int'(mode), 2);
    r0 = cyc; hcnt = 0;
    btn_inc = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      if (i == 41) btn_inc = 1'b0;
      tick();
      if (min_inc) offs.push_back(cyc - r0);
      hcnt += int'(hour_inc);
    end
    chki("hold_min_count", offs.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < offs.size()) chki($sformatf("hold_pulse%0d_offset", i), offs[i], exp_off[i]);
      else chki($sformatf("hold_pulse%0d_offset", i), -1, exp_off[i]);
    end
    chki("hold_hour_count", hcnt, 0);
    repeat (15) tick();

    // SET_M -> RUN: sec_clear with mode 00, next sec_en 10 cycles later.
    r0 = cyc; clr_at = -1; sec_at = -1; nclr = 0; early = 0; clr_mode = 2'b11;
    btn_mode = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 11) btn_mode = 1'b0;
      tick();
      if (sec_en && clr_at < 0) early++;
      if (sec_en && clr_at >= 0 && sec_at < 0) sec_at = cyc - r0;
      if (sec_clear) begin
        nclr++;
        if (clr_at < 0) begin
          clr_at = cyc - r0;
          clr_mode = mode;
        end
      end
    end
    chki("clear_offset", clr_at, 8);
    chki("clear_mode", int'(clr_mode), 0);
    chki("clear_count", nclr, 1);
    chki("first_sec_gap", sec_at - clr_at, 10);
    chki("sec_before_clear", early, 0);

    // SET_H, then both buttons at once: mode wins, no increment.
    press_mode();
    chki("mode_set_h", int'(mode), 1);
    hcnt = 0; mcnt = 0;
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 7) chki("both_mode_before", int'(mode), 1);
      if (i == 8) chki("both_mode_after", int'(mode), 2);
      hcnt += int'(hour_inc); mcnt += int'(min_inc);
    end
    chki("both_hour_inc", hcnt, 0);
    chki("both_min_inc", mcnt, 0);

    // Reset mid-hold clears outputs without waiting for a clock edge.
    #2 reset = 1'b0;
    #1;
    chk8("async_reset", outs(), O_IDLE);
    repeat (2) tick();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    reset = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk8($sformatf("post_reset_cyc%0d", i), outs(), (i == 10) ? O_SEC : O_IDLE);
    end

    chki("one_enable_per_cycle", excl_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
